// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoder control, operands and carry; supports freeze, flush and hazard bubbles.
// Optional macro ID_EX_PERF_CNT_EN adds saturating bubble_cnt/flush_cnt outputs.
module id_ex_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  hazard,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           shift_operand_in,
    input  logic [23:0]           signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic [3:0]            exec_cmd_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  wb_en_in,
    input  logic                  branch_in,
    input  logic                  s_in,
    input  logic                  carry_in,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     val_rn_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic                  imm_out,
    output logic [11:0]           shift_operand_out,
    output logic [23:0]           signed_imm_24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic [3:0]            exec_cmd_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  wb_en_out,
    output logic                  branch_out,
    output logic                  s_out,
    output logic                  carry_out,
`ifdef ID_EX_PERF_CNT_EN
    output logic [15:0]           bubble_cnt,
    output logic [15:0]           flush_cnt,
`endif
    output logic                  valid_out
);

    logic [DATA_W-1:0]     r_pc;
    logic [DATA_W-1:0]     r_val_rn;
    logic [DATA_W-1:0]     r_val_rm;
    logic                  r_imm;
    logic [11:0]           r_shift_operand;
    logic [23:0]           r_signed_imm_24;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [REG_ADDR_W-1:0] r_src1;
    logic [REG_ADDR_W-1:0] r_src2;
    logic [3:0]            r_exec_cmd;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_wb_en;
    logic                  r_branch;
    logic                  r_s;
    logic                  r_carry;
    logic                  r_valid;
    logic                  w_bubble;

    assign w_bubble = flush | hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
            r_exec_cmd      <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_wb_en         <= 1'b0;
            r_branch        <= 1'b0;
            r_s             <= 1'b0;
            r_carry         <= 1'b0;
            r_valid         <= 1'b0;
        end else if (!freeze) begin
            // A bubble clears every field so no enable can leak downstream.
            if (w_bubble) begin
                r_pc            <= '0;
                r_val_rn        <= '0;
                r_val_rm        <= '0;
                r_imm           <= 1'b0;
                r_shift_operand <= '0;
                r_signed_imm_24 <= '0;
                r_dest          <= '0;
                r_src1          <= '0;
                r_src2          <= '0;
                r_exec_cmd      <= '0;
                r_mem_read      <= 1'b0;
                r_mem_write     <= 1'b0;
                r_wb_en         <= 1'b0;
                r_branch        <= 1'b0;
                r_s             <= 1'b0;
                r_carry         <= 1'b0;
                r_valid         <= 1'b0;
            end else begin
                r_pc            <= pc_in;
                r_val_rn        <= val_rn_in;
                r_val_rm        <= val_rm_in;
                r_imm           <= imm_in;
                r_shift_operand <= shift_operand_in;
                r_signed_imm_24 <= signed_imm_24_in;
                r_dest          <= dest_in;
                r_src1          <= src1_in;
                r_src2          <= src2_in;
                r_exec_cmd      <= exec_cmd_in;
                r_mem_read      <= mem_read_in;
                r_mem_write     <= mem_write_in;
                r_wb_en         <= wb_en_in;
                r_branch        <= branch_in;
                r_s             <= s_in;
                r_carry         <= carry_in;
                r_valid         <= 1'b1;
            end
        end
    end

    assign pc_out            = r_pc;
    assign val_rn_out        = r_val_rn;
    assign val_rm_out        = r_val_rm;
    assign imm_out           = r_imm;
    assign shift_operand_out = r_shift_operand;
    assign signed_imm_24_out = r_signed_imm_24;
    assign dest_out          = r_dest;
    assign src1_out          = r_src1;
    assign src2_out          = r_src2;
    assign exec_cmd_out      = r_exec_cmd;
    assign mem_read_out      = r_mem_read;
    assign mem_write_out     = r_mem_write;
    assign wb_en_out         = r_wb_en;
    assign branch_out        = r_branch;
    assign s_out             = r_s;
    assign carry_out         = r_carry;
    assign valid_out         = r_valid;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!freeze) begin
            if (flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 16'd1;
            if (hazard && !flush && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver pushes model predictions, monitor pops and compares after each edge.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        br;
        logic        s;
        logic        c;
        logic        v;
    } bund_t;

    typedef struct packed {
        bund_t       b;
        logic [15:0] bcnt;
        logic [15:0] fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic freeze = 1'b0, flush = 1'b0, hazard = 1'b0;
    bund_t din = '0;
    bund_t dout;
    logic [15:0] bubble_cnt_w, flush_cnt_w;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .hazard(hazard),
        .pc_in(din.pc), .val_rn_in(din.rn), .val_rm_in(din.rm), .imm_in(din.imm),
        .shift_operand_in(din.shop), .signed_imm_24_in(din.simm),
        .dest_in(din.dest), .src1_in(din.s1), .src2_in(din.s2), .exec_cmd_in(din.cmd),
        .mem_read_in(din.mr), .mem_write_in(din.mw), .wb_en_in(din.wb),
        .branch_in(din.br), .s_in(din.s), .carry_in(din.c),
        .pc_out(dout.pc), .val_rn_out(dout.rn), .val_rm_out(dout.rm), .imm_out(dout.imm),
        .shift_operand_out(dout.shop), .signed_imm_24_out(dout.simm),
        .dest_out(dout.dest), .src1_out(dout.s1), .src2_out(dout.s2), .exec_cmd_out(dout.cmd),
        .mem_read_out(dout.mr), .mem_write_out(dout.mw), .wb_en_out(dout.wb),
        .branch_out(dout.br), .s_out(dout.s), .carry_out(dout.c),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt(bubble_cnt_w), .flush_cnt(flush_cnt_w),
`endif
        .valid_out(dout.v)
    );

`ifndef ID_EX_PERF_CNT_EN
    assign bubble_cnt_w = '0;
    assign flush_cnt_w  = '0;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    exp_t q[$];
    string q_name[$];

    // Reference model: what EX should hold, plus event counts
    bund_t m_state = '0;
    int    m_bcnt  = 0;
    int    m_fcnt  = 0;

    function automatic exp_t actual();
        exp_t a;
        a.b    = dout;
        a.bcnt = bubble_cnt_w;
        a.fcnt = flush_cnt_w;
        return a;
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        e.b = m_state;
`ifdef ID_EX_PERF_CNT_EN
        e.bcnt = 16'(m_bcnt);
        e.fcnt = 16'(m_fcnt);
`else
        e.bcnt = '0;
        e.fcnt = '0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input exp_t exp_v);
        exp_t a;
        a = actual();
        n_checks++;
        if (a !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, a, exp_v);
        end
    endtask

    function automatic bund_t rand_bund();
        bund_t b;
        b.pc = $urandom; b.rn = $urandom; b.rm = $urandom;
        b.imm = 1'($urandom); b.shop = 12'($urandom); b.simm = 24'($urandom);
        b.dest = 4'($urandom); b.s1 = 4'($urandom); b.s2 = 4'($urandom);
        b.cmd = 4'($urandom); b.mr = 1'($urandom); b.mw = 1'($urandom);
        b.wb = 1'($urandom); b.br = 1'($urandom); b.s = 1'($urandom);
        b.c = 1'($urandom); b.v = 1'b0;
        return b;
    endfunction

    task automatic drive(input string name, input logic f, input logic fl, input logic h, input bund_t b);
        @(negedge clk);
        freeze = f; flush = fl; hazard = h; din = b;
        if (!f) begin
            if (fl || h) m_state = '0;
            else begin
                m_state   = b;
                m_state.v = 1'b1;
            end
            if (fl) m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
            else if (h) m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
        end
        q.push_back(model_view());
        q_name.push_back(name);
    endtask

    // Asynchronous reset between edges; checked without any clock edge
    task automatic mid_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 m_state = '0; m_bcnt = 0; m_fcnt = 0;
        check("async_reset", model_view());
        #1 rst_n = 1'b1;
    endtask

    // Monitor: one registered result per edge after each driven cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                exp_t e;
                string nm;
                e  = q.pop_front();
                nm = q_name.pop_front();
                check(nm, e);
            end
        end
    end

    initial begin
        bund_t b;
        bund_t add_r3;
        int    wait_cyc;

        #3;
        check("reset_initial", model_view());
        #4 rst_n = 1'b1;

        add_r3 = '0;
        add_r3.cmd = 4'b0010; add_r3.wb = 1'b1; add_r3.rn = 32'h5;
        add_r3.dest = 4'd3; add_r3.pc = 32'h10;
        drive("normal_load", 1'b0, 1'b0, 1'b0, add_r3);

        b = '0; b.cmd = 4'b0100; b.wb = 1'b1;
        drive("hazard_bubble", 1'b0, 1'b0, 1'b1, b);
        drive("hazard_release", 1'b0, 1'b0, 1'b0, b);

        drive("freeze_load_add", 1'b0, 1'b0, 1'b0, add_r3);
        for (int unsigned i = 0; i < 3; i++)
            drive("freeze_priority", 1'b1, 1'b1, 1'b1, rand_bund());
        drive("flush_after_freeze", 1'b0, 1'b1, 1'b0, rand_bund());

        b = rand_bund(); b.br = 1'b1; b.mw = 1'b1;
        drive("flush_kills", 1'b0, 1'b1, 1'b0, b);
        drive("flush_and_hazard", 1'b0, 1'b1, 1'b1, rand_bund());
        drive("post_bubble_load", 1'b0, 1'b0, 1'b0, rand_bund());

        // Reset mid-run with all inputs nonzero, then first edge loads
        b = rand_bund(); b.pc = b.pc | 32'h1; b.cmd = 4'hF;
        drive("pre_reset_load", 1'b0, 1'b0, 1'b0, b);
        @(negedge clk);
        freeze = 1'b1; flush = 1'b1; hazard = 1'b1; din = '1;
        q.push_back(model_view());
        q_name.push_back("pre_reset_freeze");
        mid_reset();
        drive("first_after_reset", 1'b0, 1'b0, 1'b0, b);

        for (int unsigned i = 0; i < 1500; i++) begin
            logic f, fl, h;
            f  = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 5) == 0);
            h  = ($urandom_range(0, 4) == 0);
            drive("random", f, fl, h, rand_bund());
        end

`ifdef ID_EX_PERF_CNT_EN
        mid_reset();
        for (int unsigned i = 0; i < 3; i++) drive("perf_flush", 1'b0, 1'b1, 1'b0, rand_bund());
        for (int unsigned i = 0; i < 2; i++) drive("perf_hazard", 1'b0, 1'b0, 1'b1, rand_bund());
        drive("perf_both", 1'b0, 1'b1, 1'b1, rand_bund());
        for (int unsigned i = 0; i < 4; i++) drive("perf_frozen", 1'b1, 1'b1, 1'b0, rand_bund());
        @(posedge clk); #2;
        n_checks++;
        if (flush_cnt_w !== 16'd4 || bubble_cnt_w !== 16'd2) begin
            n_fails++;
            $display("FAIL perf_counts: flush_cnt=%0d bubble_cnt=%0d expected 4 and 2", flush_cnt_w, bubble_cnt_w);
        end
        for (int unsigned i = 0; i < 65540; i++)
            drive("perf_saturate", 1'b0, 1'b0, 1'b1, din);
        @(posedge clk); #2;
        n_checks++;
        if (bubble_cnt_w !== 16'hFFFF) begin
            n_fails++;
            $display("FAIL bubble_saturate: bubble_cnt=%h expected FFFF", bubble_cnt_w);
        end
`endif

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
